// File: rtl/usb_desc_reader_if.sv
// Request and byte-stream handshake between the EP0 control engine and the
// descriptor reader.
interface usb_desc_reader_if;
    logic        i_hs_mode;
    logic        i_req_valid;
    logic [7:0]  i_req_type;
    logic [7:0]  i_req_index;
    logic [15:0] i_req_wlength;
    logic        i_abort;
    logic [7:0]  o_txdat;
    logic        o_txval;
    logic        i_txrdy;
    logic        o_txlast;
    logic        o_zlp;
    logic        i_pkt_ack;
    logic        o_stall;
    logic        o_busy;

    modport slave (
        input  i_hs_mode, i_req_valid, i_req_type, i_req_index, i_req_wlength,
        input  i_abort, i_txrdy, i_pkt_ack,
        output o_txdat, o_txval, o_txlast, o_zlp, o_stall, o_busy
    );

    modport master (
        output i_hs_mode, i_req_valid, i_req_type, i_req_index, i_req_wlength,
        output i_abort, i_txrdy, i_pkt_ack,
        input  o_txdat, o_txval, o_txlast, o_zlp, o_stall, o_busy
    );
endinterface

// File: rtl/usb_desc_reader.sv
// GET_DESCRIPTOR responder: looks up a descriptor in the ROM map and streams
// it out in MAXPKT-sized packets, with ZLP termination and stall on bad requests.
module usb_desc_reader #(
    parameter int MAXPKT    = 64,
    parameter int HSSUPPORT = 1
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    usb_desc_reader_if.slave         bus,
    output logic [9:0]               o_descrom_raddr,
    input  logic [7:0]               i_descrom_rdat,
    input  logic [9:0]               i_dev_addr,
    input  logic [7:0]               i_dev_len,
    input  logic [9:0]               i_qual_addr,
    input  logic [7:0]               i_qual_len,
    input  logic [9:0]               i_fscfg_addr,
    input  logic [7:0]               i_fscfg_len,
    input  logic [9:0]               i_hscfg_addr,
    input  logic [7:0]               i_hscfg_len,
    input  logic [9:0]               i_oscfg_addr,
    input  logic [9:0]               i_strlang_addr,
    input  logic [9:0]               i_strvendor_addr,
    input  logic [7:0]               i_strvendor_len,
    input  logic [9:0]               i_strproduct_addr,
    input  logic [7:0]               i_strproduct_len,
    input  logic [9:0]               i_strserial_addr,
    input  logic [7:0]               i_strserial_len,
    input  logic                     i_have_strings
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_STREAM   = 3'd2;
    localparam logic [2:0] S_PKT_WAIT = 3'd3;
    localparam logic [2:0] S_ZLP      = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [7:0]  type_q, type_d;
    logic [7:0]  index_q, index_d;
    logic [15:0] wlen_q, wlen_d;
    logic [9:0]  base_q, base_d;
    logic [15:0] len_q, len_d;
    logic [15:0] off_q, off_d;
    logic [7:0]  pkt_q, pkt_d;
    logic        os_q, os_d;
    logic [7:0]  txdat_q, txdat_d;
    logic        txval_q, txval_d;
    logic        txlast_q, txlast_d;
    logic        zlp_q, zlp_d;
    logic        stall_q, stall_d;

    logic [9:0]  lk_base;
    logic [7:0]  lk_len;
    logic        lk_ok;
    logic [15:0] xfer_len;
    logic [9:0]  rd_base;
    logic [15:0] rd_off;
    logic        rd_os;
    logic [15:0] cur_len;
    logic        load;
    logic        pkt_start;
    logic [7:0]  pkt_next;

    always_comb begin
        lk_base = '0;
        lk_len  = '0;
        lk_ok   = 1'b1;
        case (type_q)
            8'd1: begin
                lk_base = i_dev_addr;
                lk_len  = i_dev_len;
            end
            8'd2: begin
                lk_base = bus.i_hs_mode ? i_hscfg_addr : i_fscfg_addr;
                lk_len  = bus.i_hs_mode ? i_hscfg_len  : i_fscfg_len;
            end
            8'd3: begin
                if (!i_have_strings) begin
                    lk_ok = 1'b0;
                end else begin
                    case (index_q)
                        8'd0: begin lk_base = i_strlang_addr;    lk_len = 8'd4;             end
                        8'd1: begin lk_base = i_strvendor_addr;  lk_len = i_strvendor_len;  end
                        8'd2: begin lk_base = i_strproduct_addr; lk_len = i_strproduct_len; end
                        8'd3: begin lk_base = i_strserial_addr;  lk_len = i_strserial_len;  end
                        default: lk_ok = 1'b0;
                    endcase
                end
            end
            8'd6: begin
                lk_ok   = (HSSUPPORT != 0);
                lk_base = i_qual_addr;
                lk_len  = i_qual_len;
            end
            8'd7: begin
                // other-speed reports the configuration of the speed not in use
                lk_ok   = (HSSUPPORT != 0);
                lk_base = bus.i_hs_mode ? i_fscfg_addr : i_hscfg_addr;
                lk_len  = bus.i_hs_mode ? i_fscfg_len  : i_hscfg_len;
            end
            default: lk_ok = 1'b0;
        endcase
        if (lk_len == 8'd0) begin
            lk_ok = 1'b0;
        end
        xfer_len = (wlen_q < {8'd0, lk_len}) ? wlen_q : {8'd0, lk_len};
    end

    // In LOOKUP the first byte is fetched straight from the lookup result so
    // the first data byte is registered on the LOOKUP exit edge.
    always_comb begin
        rd_base = (state_q == S_LOOKUP) ? lk_base : base_q;
        rd_off  = (state_q == S_LOOKUP) ? '0 : off_q;
        rd_os   = (state_q == S_LOOKUP) ? (type_q == 8'd7) : os_q;
        cur_len = (state_q == S_LOOKUP) ? xfer_len : len_q;
        if (rd_os && (rd_off == 16'd1)) begin
            o_descrom_raddr = i_oscfg_addr;
        end else begin
            o_descrom_raddr = rd_base + rd_off[9:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        index_d   = index_q;
        wlen_d    = wlen_q;
        base_d    = base_q;
        len_d     = len_q;
        off_d     = off_q;
        pkt_d     = pkt_q;
        os_d      = os_q;
        txdat_d   = txdat_q;
        txval_d   = txval_q;
        txlast_d  = txlast_q;
        zlp_d     = 1'b0;
        stall_d   = 1'b0;
        load      = 1'b0;
        pkt_start = 1'b0;
        pkt_next  = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req_valid) begin
                    type_d  = bus.i_req_type;
                    index_d = bus.i_req_index;
                    wlen_d  = bus.i_req_wlength;
                    off_d   = '0;
                    pkt_d   = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!lk_ok) begin
                    stall_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    base_d = lk_base;
                    len_d  = xfer_len;
                    os_d   = (type_q == 8'd7);
                    if (xfer_len == 16'd0) begin
                        zlp_d   = 1'b1;
                        state_d = S_ZLP;
                    end else begin
                        load      = 1'b1;
                        pkt_start = 1'b1;
                        state_d   = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (txval_q && bus.i_txrdy) begin
                    if (txlast_q) begin
                        txval_d  = 1'b0;
                        txlast_d = 1'b0;
                        state_d  = S_PKT_WAIT;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            S_PKT_WAIT: begin
                if (bus.i_pkt_ack) begin
                    if (off_q < len_q) begin
                        load      = 1'b1;
                        pkt_start = 1'b1;
                        state_d   = S_STREAM;
                    end else if ((len_q < wlen_q) && ((len_q % 16'(MAXPKT)) == 16'd0)) begin
                        zlp_d   = 1'b1;
                        state_d = S_ZLP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_ZLP: begin
                if (bus.i_pkt_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            pkt_next = (pkt_start ? 8'd0 : pkt_q) + 8'd1;
            txval_d  = 1'b1;
            txdat_d  = i_descrom_rdat;
            off_d    = rd_off + 16'd1;
            pkt_d    = pkt_next;
            txlast_d = ((rd_off + 16'd1) == cur_len) || (pkt_next == 8'(MAXPKT));
        end

        if (bus.i_abort) begin
            state_d  = S_IDLE;
            txval_d  = 1'b0;
            txlast_d = 1'b0;
            zlp_d    = 1'b0;
            stall_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            type_q   <= '0;
            index_q  <= '0;
            wlen_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            off_q    <= '0;
            pkt_q    <= '0;
            os_q     <= 1'b0;
            txdat_q  <= '0;
            txval_q  <= 1'b0;
            txlast_q <= 1'b0;
            zlp_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            index_q  <= index_d;
            wlen_q   <= wlen_d;
            base_q   <= base_d;
            len_q    <= len_d;
            off_q    <= off_d;
            pkt_q    <= pkt_d;
            os_q     <= os_d;
            txdat_q  <= txdat_d;
            txval_q  <= txval_d;
            txlast_q <= txlast_d;
            zlp_q    <= zlp_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.o_txdat  = txdat_q;
    assign bus.o_txval  = txval_q;
    assign bus.o_txlast = txlast_q;
    assign bus.o_zlp    = zlp_q;
    assign bus.o_stall  = stall_q;
    assign bus.o_busy   = (state_q != S_IDLE);

endmodule
